float_add_seq: RTL and testbench
================================

# float_add_seq

Multi-cycle half-precision (1/5/10, bias 15) floating-point adder with valid/ready handshakes on both sides. It is the addition counterpart of the team's combinational half-precision subtractor. Alignment and normalization are done one bit per cycle, trading latency for area. It sits between the operand register file and the result writeback stage of the float datapath.

## Interface
- No parameters; format fixed at 16 bits (sign [15], exponent [14:10], mantissa [9:0]).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands; equals (state == IDLE)
- float_a  in  16  operand A
- float_b  in  16  operand B
- out_valid  out  1  sum/flags valid
- out_ready  in  1  consumer accepts result
- sum  out  16  A + B
- ovf  out  1  result overflowed (exponent ≥ 31)
- unf  out  1  result underflowed (flushed to zero)

## Operation
- **FSM states:** IDLE, ALIGN, ADD, NORM, DONE.
- **IDLE:**
  - Accept when in_valid & in_ready.
  - Operands are captured; hidden bit = 1; fractions are 11 bits.
- **Zero operands:** an operand with exponent 0 is zero (no subnormals). Special cases go straight to DONE:
  - A zero → sum = B.
  - B zero → sum = A.
  - A, B magnitudes equal with opposite signs → sum = 0x0000.
- **Ordering:** the larger operand is the one with the greater {exp,frac}; it supplies the result exponent and result sign. d = |expA − expB|, capped at 12.
- **ALIGN:**
  - Each cycle: if cnt == 0 → ADD; otherwise shift the smaller fraction right by 1 and decrement cnt.
  - Shifted-out bits are discarded (truncation; no guard/round bits).
- **ADD:** one cycle, 12-bit result.
  - Same signs: large + small.
  - Different signs: large − small (never negative).
- **NORM:** checks once per cycle, in priority order:
  - Carry (bit 11 set) → shift right 1, exp + 1, go to DONE.
  - Fraction == 0 → result +0, go to DONE.
  - Bit 10 clear → shift left 1, exp − 1, stay in NORM.
  - Otherwise → go to DONE.
- **Overflow:** result exponent ≥ 31 → ovf = 1; the result pattern is set by the configuration macro.
- **Underflow:** result exponent ≤ 0 → sum = 0x0000, unf = 1.
- **Exponent-31 inputs:** treated as ordinary finite values; there is no Inf/NaN semantics.
- **DONE:**
  - out_valid = 1; sum, ovf and unf are held stable.
  - When out_ready → IDLE.

## Timing
- **Reset values:** state IDLE, in_ready = 1, out_valid = 0, sum = 0x0000, ovf = 0, unf = 0. Assertion at any point aborts the operation in flight; no result is emitted.
- **Latency (normal path):** out_valid rises (min(d,12)+1) + 1 + (s+1) clock edges after the accept edge, where s = number of NORM left shifts (0 on the carry path).
- **Latency (special cases):** out_valid rises 1 edge after the accept edge.
- **Output hold:** out_valid stays high until the out_ready edge.
  - out_ready low for N cycles → outputs frozen.
  - in_ready is low in every state except IDLE.
- **Back-to-back:** DONE → IDLE costs one cycle. A new operand pair is accepted no earlier than the edge after the result handoff.
- **Control inputs:** in_valid is ignored outside IDLE; out_ready is ignored outside DONE.

## Configuration
- **FLOAT_ADD_SAT_EN defined:** overflow returns {sign, 15'h7BFF} (max finite).
- **FLOAT_ADD_SAT_EN undefined:** overflow returns {sign, 15'h7C00}.
- In both cases ovf = 1.

## Test plan
- **Carry path:** 0x3C00 + 0x3C00, out_ready = 1.
  - sum = 0x4000, ovf = unf = 0.
  - out_valid 3 edges after accept.
- **Align + normalize:** 0x3C00 + 0xB800.
  - sum = 0x3800.
  - out_valid 5 edges after accept (d = 1, s = 1).
- **Special cases:**
  - 0x0000 + 0xC500 → 0xC500 at 1 edge.
  - 0x4248 + 0xC248 → 0x0000 at 1 edge.
- **Overflow:** 0x7BFF + 0x7BFF.
  - ovf = 1.
  - sum = 0x7BFF with FLOAT_ADD_SAT_EN, 0x7C00 without.
- **Backpressure and reset:**
  - Hold out_ready = 0 for 5 cycles → sum stable, in_ready = 0; a second in_valid is not accepted until after the handoff.
  - Assert rst during ALIGN of 0x3C00 + 0x1400 → all outputs at reset values; the next accepted pair completes correctly.
- **Cancellation underflow:** 0x0401 + 0x8400 (difference below the minimum normal).
  - sum = 0x0000, unf = 1.

Source files
------------

// File: rtl/float_add_seq.sv
// Multi-cycle half-precision adder: one-bit-per-cycle alignment and normalization.
// Define FLOAT_ADD_SAT_EN to saturate overflow to max finite instead of the 0x7C00 pattern.
module float_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] float_a,
    input  logic [15:0] float_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t             state_reg;
    logic               sign_reg;
    logic signed [6:0]  exp_reg;
    logic [10:0]        large_reg;
    logic [10:0]        small_reg;
    logic               op_sub_reg;
    logic [3:0]         cnt_reg;
    logic [11:0]        frac_reg;
    logic               special_reg;
    logic [15:0]        sum_reg;
    logic               ovf_reg;
    logic               unf_reg;
    logic               out_valid_reg;

    logic               a_zero, b_zero, cancel, a_larger, special;
    logic [15:0]        special_sum;
    logic [4:0]         exp_diff;
    logic [3:0]         cnt_init;
    logic [17:0]        pack_carry, pack_plain;

    // Packs {ovf, unf, sum} from a signed working exponent and an 11-bit fraction.
    function automatic logic [17:0] pack(input logic s, input logic signed [6:0] e,
                                         input logic [10:0] f);
        logic [17:0] r;
        r = 18'd0;
        if (e >= 7'sd31) begin
`ifdef FLOAT_ADD_SAT_EN
            r = {1'b1, 1'b0, s, 15'h7BFF};
`else
            r = {1'b1, 1'b0, s, 15'h7C00};
`endif
        end else if (e <= 7'sd0) begin
            r = {1'b0, 1'b1, 16'h0000};
        end else begin
            r = {1'b0, 1'b0, s, e[4:0], f[9:0]};
        end
        return r;
    endfunction

    always_comb begin
        a_zero      = (float_a[14:10] == 5'd0);
        b_zero      = (float_b[14:10] == 5'd0);
        cancel      = (float_a[14:0] == float_b[14:0]) && (float_a[15] != float_b[15]);
        a_larger    = (float_a[14:0] >= float_b[14:0]);
        special     = a_zero || b_zero || cancel;
        special_sum = 16'h0000;
        if (a_zero)
            special_sum = float_b;
        else if (b_zero)
            special_sum = float_a;
        exp_diff    = a_larger ? (float_a[14:10] - float_b[14:10])
                               : (float_b[14:10] - float_a[14:10]);
        cnt_init    = (exp_diff > 5'd12) ? 4'd12 : exp_diff[3:0];
        pack_carry  = pack(sign_reg, exp_reg + 7'sd1, frac_reg[11:1]);
        pack_plain  = pack(sign_reg, exp_reg, frac_reg[10:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sign_reg      <= 1'b0;
            exp_reg       <= 7'sd0;
            large_reg     <= 11'd0;
            small_reg     <= 11'd0;
            op_sub_reg    <= 1'b0;
            cnt_reg       <= 4'd0;
            frac_reg      <= 12'd0;
            special_reg   <= 1'b0;
            sum_reg       <= 16'h0000;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        special_reg <= special;
                        op_sub_reg  <= float_a[15] ^ float_b[15];
                        cnt_reg     <= cnt_init;
                        if (special) begin
                            sum_reg <= special_sum;
                            ovf_reg <= 1'b0;
                            unf_reg <= 1'b0;
                        end
                        if (a_larger) begin
                            sign_reg  <= float_a[15];
                            exp_reg   <= $signed({2'b00, float_a[14:10]});
                            large_reg <= {1'b1, float_a[9:0]};
                            small_reg <= {1'b1, float_b[9:0]};
                        end else begin
                            sign_reg  <= float_b[15];
                            exp_reg   <= $signed({2'b00, float_b[14:10]});
                            large_reg <= {1'b1, float_b[9:0]};
                            small_reg <= {1'b1, float_a[9:0]};
                        end
                        state_reg <= ALIGN;
                    end
                end
                ALIGN: begin
                    // Special cases park here for one cycle so their latency is fixed at one edge.
                    if (special_reg) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg <= ADD;
                    end else begin
                        small_reg <= small_reg >> 1;
                        cnt_reg   <= cnt_reg - 4'd1;
                    end
                end
                ADD: begin
                    if (op_sub_reg)
                        frac_reg <= {1'b0, large_reg} - {1'b0, small_reg};
                    else
                        frac_reg <= {1'b0, large_reg} + {1'b0, small_reg};
                    state_reg <= NORM;
                end
                NORM: begin
                    if (frac_reg[11]) begin
                        {ovf_reg, unf_reg, sum_reg} <= pack_carry;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (frac_reg == 12'd0) begin
                        {ovf_reg, unf_reg, sum_reg} <= 18'd0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (!frac_reg[10]) begin
                        frac_reg <= {frac_reg[10:0], 1'b0};
                        exp_reg  <= exp_reg - 7'sd1;
                    end else begin
                        {ovf_reg, unf_reg, sum_reg} <= pack_plain;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign ovf       = ovf_reg;
    assign unf       = unf_reg;

endmodule

// File: tb/tb_float_add_seq.sv
// Directed-vector bench for float_add_seq: result values, flags, latency, backpressure, reset abort.
module tb_float_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] float_a;
    logic [15:0] float_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        ovf;
    logic        unf;

    int errors = 0;
    int checks = 0;

    float_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_a   (float_a),
        .float_b   (float_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        logic        exp_unf;
        int          exp_lat;
    } vec_t;

`ifdef FLOAT_ADD_SAT_EN
    localparam logic [15:0] OVF_SUM = 16'h7BFF;
`else
    localparam logic [15:0] OVF_SUM = 16'h7C00;
`endif

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Accepts one pair, waits (bounded) for out_valid, returns the result and the edge count.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] s, output logic o, output logic u, output int lat);
        @(negedge clk);
        float_a  = a;
        float_b  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s = sum;
        o = ovf;
        u = unf;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic        o, u;
        int          lat;

        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0, 3};
        vecs[1]  = '{16'h3C00, 16'hB800, 16'h3800, 1'b0, 1'b0, 5};
        vecs[2]  = '{16'h0000, 16'hC500, 16'hC500, 1'b0, 1'b0, 1};
        vecs[3]  = '{16'h4248, 16'hC248, 16'h0000, 1'b0, 1'b0, 1};
        vecs[4]  = '{16'h7BFF, 16'h7BFF, OVF_SUM,  1'b1, 1'b0, 3};
        vecs[5]  = '{16'h0401, 16'h8400, 16'h0000, 1'b0, 1'b1, 13};
        vecs[6]  = '{16'h4000, 16'h3C00, 16'h4200, 1'b0, 1'b0, 4};
        vecs[7]  = '{16'hC500, 16'h0000, 16'hC500, 1'b0, 1'b0, 1};
        vecs[8]  = '{16'h3C00, 16'h1400, 16'h3C01, 1'b0, 1'b0, 13};
        vecs[9]  = '{16'h5000, 16'h0400, 16'h5000, 1'b0, 1'b0, 15};
        vecs[10] = '{16'hC000, 16'h3C00, 16'hBC00, 1'b0, 1'b0, 5};
        vecs[11] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        float_a   = 16'h0000;
        float_b   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'h0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset unf", 32'(unf), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, s, o, u, lat);
            $display("vec %0d: %h + %h -> sum=%h ovf=%0d unf=%0d lat=%0d", i,
                     vecs[i].a, vecs[i].b, s, o, u, lat);
            chk($sformatf("vec%0d sum", i), 32'(s), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d unf", i), 32'(u), 32'(vecs[i].exp_unf));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Backpressure: result held while a second pair waits on in_valid.
        @(negedge clk);
        float_a  = 16'h3C00;
        float_b  = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        float_a = 16'h4000;
        float_b = 16'h4000;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d sum", k), 32'(sum), 32'h4000);
            chk($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp handoff out_valid", 32'(out_valid), 32'd0);
        chk("bp handoff in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("bp second: 4000 + 4000 -> sum=%h lat=%0d", sum, lat);
        chk("bp second sum", 32'(sum), 32'h4400);
        chk("bp second latency", 32'(lat), 32'd3);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while aligning a d=10 pair aborts it; no result afterwards.
        @(negedge clk);
        float_a  = 16'h3C00;
        float_b  = 16'h1400;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst abort out_valid", 32'(out_valid), 32'd0);
        chk("rst abort in_ready", 32'(in_ready), 32'd1);
        chk("rst abort sum", 32'(sum), 32'h0);
        chk("rst abort ovf", 32'(ovf), 32'd0);
        chk("rst abort unf", 32'(unf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst no result", 32'(out_valid), 32'd0);
        run_op(16'h3C00, 16'h1400, s, o, u, lat);
        $display("after reset: 3c00 + 1400 -> sum=%h ovf=%0d unf=%0d lat=%0d", s, o, u, lat);
        chk("post-rst sum", 32'(s), 32'h3C01);
        chk("post-rst latency", 32'(lat), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
